// File: rtl/imm_prefix_extender.sv
// Registered immediate extender with chained PFX immediates for wide constants.
// Build option IMM_ZEXT_EN adds i_zext to zero-extend I/J consumers.
module imm_prefix_extender #(
   parameter int DATA_WIDTH    = 36,
   parameter int SELECT_WIDTH  = 2,
   parameter int IMM_MAX_WIDTH = 14,
   parameter int I_IMM_WIDTH   = 8,
   parameter int J_IMM_WIDTH   = 14,
   parameter int MAX_PREFIX    = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_valid,
   input  logic                     i_stall,
   input  logic                     i_flush,
   input  logic [IMM_MAX_WIDTH-1:0] i_immRaw,
   input  logic [SELECT_WIDTH-1:0]  i_immSel,
`ifdef IMM_ZEXT_EN
   input  logic                     i_zext,
`endif
   output logic [DATA_WIDTH-1:0]    o_imm_ext,
   output logic                     o_valid,
   output logic                     o_pfx_pending,
   output logic                     o_pfx_overflow,
   output logic                     o_pfx_orphan
);

   localparam logic [SELECT_WIDTH-1:0] SEL_NONE = SELECT_WIDTH'(0);
   localparam logic [SELECT_WIDTH-1:0] SEL_I    = SELECT_WIDTH'(1);
   localparam logic [SELECT_WIDTH-1:0] SEL_J    = SELECT_WIDTH'(2);
   localparam logic [SELECT_WIDTH-1:0] SEL_PFX  = SELECT_WIDTH'(3);

   localparam int ACC_W  = MAX_PREFIX * J_IMM_WIDTH;
   localparam int CNT_W  = $clog2(MAX_PREFIX + 1);
   localparam int FULL_W = ACC_W + J_IMM_WIDTH + DATA_WIDTH;

   logic [ACC_W-1:0] pfxAcc;
   logic [CNT_W-1:0] pfxCnt;
   logic             zextEff;

`ifdef IMM_ZEXT_EN
   assign zextEff = i_zext;
`else
   assign zextEff = 1'b0;
`endif

   assign o_pfx_pending = (pfxCnt != '0);

   // Builds {acc[cnt*J-1:0], raw[B-1:0]} and extends it from its own top bit.
   function automatic logic [DATA_WIDTH-1:0] extendImm(
      input logic [ACC_W-1:0]         acc,
      input logic [CNT_W-1:0]         cnt,
      input logic [IMM_MAX_WIDTH-1:0] raw,
      input logic                     isJ,
      input logic                     zext
   );
      int              baseW;
      int              pfxW;
      int              w;
      logic [FULL_W-1:0] ones;
      logic [FULL_W-1:0] accPart;
      logic [FULL_W-1:0] rawPart;
      logic [FULL_W-1:0] comp;
      baseW   = isJ ? J_IMM_WIDTH : I_IMM_WIDTH;
      pfxW    = int'(cnt) * J_IMM_WIDTH;
      w       = baseW + pfxW;
      ones    = '1;
      accPart = FULL_W'(acc) & ~(ones << pfxW);
      rawPart = FULL_W'(raw) & ~(ones << baseW);
      comp    = (accPart << baseW) | rawPart;
      if (!zext && (w < DATA_WIDTH) && ((comp >> (w - 1)) != '0))
         comp = comp | (ones << w);
      return comp[DATA_WIDTH-1:0];
   endfunction

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_imm_ext      <= '0;
         o_valid        <= 1'b0;
         o_pfx_overflow <= 1'b0;
         o_pfx_orphan   <= 1'b0;
         pfxAcc         <= '0;
         pfxCnt         <= '0;
      end else if (i_flush) begin
         o_valid        <= 1'b0;
         o_pfx_overflow <= 1'b0;
         o_pfx_orphan   <= 1'b0;
         pfxAcc         <= '0;
         pfxCnt         <= '0;
      end else if (i_stall) begin
         o_pfx_overflow <= 1'b0;
         o_pfx_orphan   <= 1'b0;
      end else begin
         o_valid        <= 1'b0;
         o_pfx_overflow <= 1'b0;
         o_pfx_orphan   <= 1'b0;
         if (i_valid) begin
            case (i_immSel)
               SEL_PFX: begin
                  pfxAcc <= (pfxAcc << J_IMM_WIDTH) | ACC_W'(i_immRaw[J_IMM_WIDTH-1:0]);
                  if (pfxCnt == CNT_W'(MAX_PREFIX))
                     o_pfx_overflow <= 1'b1;
                  else
                     pfxCnt <= pfxCnt + CNT_W'(1);
               end
               SEL_I, SEL_J: begin
                  o_imm_ext <= extendImm(pfxAcc, pfxCnt, i_immRaw, (i_immSel == SEL_J), zextEff);
                  o_valid   <= 1'b1;
                  pfxAcc    <= '0;
                  pfxCnt    <= '0;
               end
               default: begin
                  o_imm_ext <= '0;
                  o_valid   <= 1'b1;
                  if (pfxCnt != '0) begin
                     o_pfx_orphan <= 1'b1;
                     pfxAcc       <= '0;
                     pfxCnt       <= '0;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imm_prefix_extender.sv
// Bench for imm_prefix_extender: directed scenarios plus randomized traffic
// against a queue-based model of pending prefixes.
module tb_imm_prefix_extender;

   localparam int DW  = 36;
   localparam int MAXP = 2;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_valid = 1'b0;
   logic          i_stall = 1'b0;
   logic          i_flush = 1'b0;
   logic [13:0]   i_immRaw = '0;
   logic [1:0]    i_immSel = '0;
   logic          zext = 1'b0;
   logic [DW-1:0] o_imm_ext;
   logic          o_valid;
   logic          o_pfx_pending;
   logic          o_pfx_overflow;
   logic          o_pfx_orphan;

   int nCmp = 0;
   int nErr = 0;

   // model state
   logic [13:0]   pfxQ[$];
   logic [DW-1:0] mImm = '0;
   logic          mValid = 1'b0;
   logic          mOvf = 1'b0;
   logic          mOrph = 1'b0;
   logic          mPend;

   always #5 i_clk = ~i_clk;

   imm_prefix_extender #(
      .DATA_WIDTH(36), .SELECT_WIDTH(2), .IMM_MAX_WIDTH(14),
      .I_IMM_WIDTH(8), .J_IMM_WIDTH(14), .MAX_PREFIX(MAXP)
   ) dut (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_valid(i_valid),
      .i_stall(i_stall),
      .i_flush(i_flush),
      .i_immRaw(i_immRaw),
      .i_immSel(i_immSel),
`ifdef IMM_ZEXT_EN
      .i_zext(zext),
`endif
      .o_imm_ext(o_imm_ext),
      .o_valid(o_valid),
      .o_pfx_pending(o_pfx_pending),
      .o_pfx_overflow(o_pfx_overflow),
      .o_pfx_orphan(o_pfx_orphan)
   );

   function automatic logic [DW-1:0] modelCompose(input logic [13:0] raw, input bit isJ, input bit zx);
      longint unsigned comp;
      int b;
      int w;
      b = isJ ? 14 : 8;
      comp = 0;
      foreach (pfxQ[k]) comp = (comp << 14) | longint'(pfxQ[k]);
      comp = (comp << b) | (longint'(raw) & ((64'd1 << b) - 64'd1));
      w = b + 14 * pfxQ.size();
      if (!zx && w < DW && comp[w-1]) comp = comp | (~64'd0 << w);
      return comp[DW-1:0];
   endfunction

   // Presents one cycle of inputs, advances the model, then samples past the edge.
   task automatic step(input logic v, input logic [1:0] s, input logic [13:0] r,
                       input logic st, input logic fl, input logic rn, input logic z);
      bit zx;
      i_valid = v; i_immSel = s; i_immRaw = r;
      i_stall = st; i_flush = fl; i_rst_n = rn; zext = z;
`ifdef IMM_ZEXT_EN
      zx = z;
`else
      zx = 1'b0;
`endif
      if (!rn) begin
         mImm = '0; mValid = 0; mOvf = 0; mOrph = 0; pfxQ.delete();
      end else if (fl) begin
         mValid = 0; mOvf = 0; mOrph = 0; pfxQ.delete();
      end else if (st) begin
         mOvf = 0; mOrph = 0;
      end else begin
         mValid = 0; mOvf = 0; mOrph = 0;
         if (v) begin
            if (s == 2'd3) begin
               pfxQ.push_back(r);
               if (pfxQ.size() > MAXP) begin
                  void'(pfxQ.pop_front());
                  mOvf = 1;
               end
            end else if (s == 2'd0) begin
               mImm = '0; mValid = 1;
               if (pfxQ.size() > 0) begin
                  mOrph = 1; pfxQ.delete();
               end
            end else begin
               mImm = modelCompose(r, s == 2'd2, zx);
               mValid = 1;
               pfxQ.delete();
            end
         end
      end
      mPend = (pfxQ.size() > 0);
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      step(1, 2'd1, 14'h0055, 0, 0, 0, 0);
      step(1, 2'd3, 14'h0011, 1, 1, 0, 0);
      nCmp++;
      if ({o_imm_ext, o_valid, o_pfx_pending, o_pfx_overflow, o_pfx_orphan} !== {36'h0, 4'b0000}) begin
         nErr++;
         $display("FAIL reset: got imm=%h v=%b p=%b ov=%b or=%b, want all zero",
                  o_imm_ext, o_valid, o_pfx_pending, o_pfx_overflow, o_pfx_orphan);
      end
   endtask

   task automatic test_sign_i();
      step(1, 2'd1, 14'h0080, 0, 0, 1, 0);
      nCmp++;
      if ({o_imm_ext, o_valid, o_pfx_pending} !== {36'hFFFFFFF80, 1'b1, 1'b0}) begin
         nErr++;
         $display("FAIL sign_i: got imm=%h v=%b p=%b, want FFFFFFF80 1 0", o_imm_ext, o_valid, o_pfx_pending);
      end
      step(0, 2'd1, 14'h0000, 0, 0, 1, 0);
      nCmp++;
      if ({o_imm_ext, o_valid} !== {36'hFFFFFFF80, 1'b0}) begin
         nErr++;
         $display("FAIL idle_hold: got imm=%h v=%b, want FFFFFFF80 0", o_imm_ext, o_valid);
      end
   endtask

   task automatic test_prefix_chain();
      step(1, 2'd3, 14'h0001, 0, 0, 1, 0);
      nCmp++;
      if ({o_valid, o_pfx_pending} !== 2'b01) begin
         nErr++;
         $display("FAIL pfx_pending: got v=%b p=%b, want 0 1", o_valid, o_pfx_pending);
      end
      step(1, 2'd1, 14'h0023, 0, 0, 1, 0);
      nCmp++;
      if ({o_imm_ext, o_valid, o_pfx_pending} !== {36'h000000123, 1'b1, 1'b0}) begin
         nErr++;
         $display("FAIL pfx_consume: got imm=%h v=%b p=%b, want 000000123 1 0", o_imm_ext, o_valid, o_pfx_pending);
      end
   endtask

   task automatic test_full_width();
      step(1, 2'd3, 14'h2000, 0, 0, 1, 0);
      step(1, 2'd3, 14'h0000, 0, 0, 1, 0);
      step(1, 2'd1, 14'h0000, 0, 0, 1, 0);
      nCmp++;
      if (o_imm_ext !== 36'h800000000) begin
         nErr++;
         $display("FAIL full_width: got %h, want 800000000", o_imm_ext);
      end
      step(1, 2'd2, 14'h2000, 0, 0, 1, 0);
      nCmp++;
      if (o_imm_ext !== 36'hFFFFFE000) begin
         nErr++;
         $display("FAIL sign_j: got %h, want FFFFFE000", o_imm_ext);
      end
   endtask

   task automatic test_overflow();
      step(1, 2'd3, 14'h0001, 0, 0, 1, 0);
      step(1, 2'd3, 14'h0002, 0, 0, 1, 0);
      nCmp++;
      if (o_pfx_overflow !== 1'b0) begin
         nErr++;
         $display("FAIL ovf_early: got %b, want 0", o_pfx_overflow);
      end
      step(1, 2'd3, 14'h0003, 0, 0, 1, 0);
      nCmp++;
      if ({o_pfx_overflow, o_pfx_pending} !== 2'b11) begin
         nErr++;
         $display("FAIL ovf_pulse: got ov=%b p=%b, want 1 1", o_pfx_overflow, o_pfx_pending);
      end
      step(1, 2'd2, 14'h0000, 0, 0, 1, 0);
      nCmp++;
      if ({o_imm_ext, o_pfx_overflow, o_valid} !== {36'h02000C000, 1'b0, 1'b1}) begin
         nErr++;
         $display("FAIL ovf_consume: got imm=%h ov=%b v=%b, want 02000C000 0 1", o_imm_ext, o_pfx_overflow, o_valid);
      end
   endtask

   task automatic test_orphan();
      step(1, 2'd3, 14'h3FFF, 0, 0, 1, 0);
      step(1, 2'd0, 14'h1234, 0, 0, 1, 0);
      nCmp++;
      if ({o_imm_ext, o_valid, o_pfx_orphan, o_pfx_pending} !== {36'h0, 3'b110}) begin
         nErr++;
         $display("FAIL orphan: got imm=%h v=%b or=%b p=%b, want 0 1 1 0", o_imm_ext, o_valid, o_pfx_orphan, o_pfx_pending);
      end
      step(1, 2'd1, 14'h007F, 0, 0, 1, 0);
      nCmp++;
      if ({o_imm_ext, o_pfx_orphan} !== {36'h00000007F, 1'b0}) begin
         nErr++;
         $display("FAIL after_orphan: got imm=%h or=%b, want 00000007F 0", o_imm_ext, o_pfx_orphan);
      end
   endtask

   task automatic test_stall();
      step(1, 2'd3, 14'h0001, 0, 0, 1, 0);
      for (int k = 0; k < 3; k++) begin
         step(1, 2'd1, 14'h0045, 1, 0, 1, 0);
         nCmp++;
         if ({o_imm_ext, o_valid, o_pfx_pending} !== {36'h00000007F, 1'b0, 1'b1}) begin
            nErr++;
            $display("FAIL stall_hold%0d: got imm=%h v=%b p=%b, want 00000007F 0 1", k, o_imm_ext, o_valid, o_pfx_pending);
         end
      end
      step(1, 2'd1, 14'h0045, 0, 0, 1, 0);
      nCmp++;
      if ({o_imm_ext, o_valid} !== {36'h000000145, 1'b1}) begin
         nErr++;
         $display("FAIL stall_release: got imm=%h v=%b, want 000000145 1", o_imm_ext, o_valid);
      end
   endtask

   task automatic test_flush_reset();
      step(1, 2'd3, 14'h0001, 0, 0, 1, 0);
      step(1, 2'd3, 14'h0002, 0, 1, 1, 0);
      nCmp++;
      if ({o_imm_ext, o_valid, o_pfx_pending} !== {36'h000000145, 1'b0, 1'b0}) begin
         nErr++;
         $display("FAIL flush: got imm=%h v=%b p=%b, want 000000145 0 0", o_imm_ext, o_valid, o_pfx_pending);
      end
      step(1, 2'd1, 14'h0005, 0, 0, 1, 0);
      nCmp++;
      if (o_imm_ext !== 36'h000000005) begin
         nErr++;
         $display("FAIL flush_consume: got %h, want 000000005", o_imm_ext);
      end
      step(1, 2'd3, 14'h0001, 0, 0, 1, 0);
      step(0, 2'd0, 14'h0000, 0, 0, 0, 0);
      step(1, 2'd1, 14'h0005, 0, 0, 1, 0);
      nCmp++;
      if (o_imm_ext !== 36'h000000005) begin
         nErr++;
         $display("FAIL reset_consume: got %h, want 000000005", o_imm_ext);
      end
   endtask

`ifdef IMM_ZEXT_EN
   task automatic test_zext();
      step(1, 2'd1, 14'h0080, 0, 0, 1, 1);
      nCmp++;
      if (o_imm_ext !== 36'h000000080) begin
         nErr++;
         $display("FAIL zext: got %h, want 000000080", o_imm_ext);
      end
   endtask
`endif

   task automatic test_random();
      logic v, st, fl, rn, z;
      logic [1:0] s;
      logic [13:0] r;
      for (int n = 0; n < 400; n++) begin
         v  = ($urandom_range(0, 9) < 8);
         s  = 2'($urandom_range(0, 3));
         r  = 14'($urandom);
         st = ($urandom_range(0, 99) < 15);
         fl = ($urandom_range(0, 99) < 5);
         rn = ($urandom_range(0, 99) >= 3);
         z  = 1'($urandom);
         step(v, s, r, st, fl, rn, z);
         nCmp++;
         if ({o_imm_ext, o_valid, o_pfx_pending, o_pfx_overflow, o_pfx_orphan} !==
             {mImm, mValid, mPend, mOvf, mOrph}) begin
            nErr++;
            $display("FAIL random%0d: got imm=%h v=%b p=%b ov=%b or=%b, want imm=%h v=%b p=%b ov=%b or=%b",
                     n, o_imm_ext, o_valid, o_pfx_pending, o_pfx_overflow, o_pfx_orphan,
                     mImm, mValid, mPend, mOvf, mOrph);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sign_i();
      test_prefix_chain();
      test_full_width();
      test_overflow();
      test_orphan();
      test_stall();
      test_flush_reset();
`ifdef IMM_ZEXT_EN
      test_zext();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
